// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Bridges the execute stage and a word-addressed data memory for RV32I
// loads and stores.
//   - Loads (LB/LH/LW/LBU/LHU): zero latency, lane-selected, sign/zero
//     extended from the combinational memory read path.
//   - SW: single-cycle full-word write.
//   - SB/SH: two-cycle read-modify-write (read + stall, then merged write),
//     because the memory only accepts whole words.
//   - Misaligned accesses and illegal funct3 codes are rejected; the address
//     of the latest rejected access is held in fault_addr.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_we/req_funct3/req_addr/req_wdata   request from execute
//   load_data                  extended load result (same cycle)
//   stall                      pipeline hold during the RMW read cycle
//   misalign                   current request rejected (combinational)
//   fault_addr                 address of most recent rejected request
//   dm_addr/dm_wdata/dm_we/dm_re/dm_rdata   word-addressed memory port
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic [XLEN-1:0]   load_data,
    output logic              stall,
    output logic              misalign,
    output logic [ADDR_W-1:0] fault_addr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [XLEN-1:0]   dm_wdata,
    output logic              dm_we,
    output logic              dm_re,
    input  logic [XLEN-1:0]   dm_rdata
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [XLEN-1:0]   rmw_word_r;
    logic [ADDR_W-1:0] cap_addr_r;
    logic [1:0]        cap_off_r;
    logic              cap_half_r;
    logic [15:0]       cap_data_r;
    logic [ADDR_W-1:0] fault_addr_r;
    logic              capture_s;
    logic              fault_s;
    logic              legal_s;
    logic              aligned_s;

    // Select the addressed byte/half lane of a memory word and extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Replace one byte or half lane of the captured word with store data.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic        half,
                                               input logic [15:0] data);
        logic [31:0] r;
        r = word;
        if (half) begin
            if (off[1]) begin
                r[31:16] = data;
            end else begin
                r[15:0] = data;
            end
        end else begin
            case (off)
                2'd0:    r[7:0]   = data[7:0];
                2'd1:    r[15:8]  = data[7:0];
                2'd2:    r[23:16] = data[7:0];
                2'd3:    r[31:24] = data[7:0];
                default: r        = word;
            endcase
        end
        return r;
    endfunction

    // Legality of funct3 for the request direction and its natural alignment.
    always_comb begin
        legal_s   = 1'b0;
        aligned_s = 1'b0;
        case (req_funct3)
            3'b000: begin
                legal_s   = 1'b1;
                aligned_s = 1'b1;
            end
            3'b001: begin
                legal_s   = 1'b1;
                aligned_s = ~req_addr[0];
            end
            3'b010: begin
                legal_s   = 1'b1;
                aligned_s = (req_addr[1:0] == 2'b00);
            end
            3'b100: begin
                legal_s   = ~req_we;
                aligned_s = 1'b1;
            end
            3'b101: begin
                legal_s   = ~req_we;
                aligned_s = ~req_addr[0];
            end
            default: begin
                legal_s   = 1'b0;
                aligned_s = 1'b0;
            end
        endcase
    end

    // Next-state and memory/pipeline strobes; outputs forced quiet while in reset.
    always_comb begin
        state_next_s = state_r;
        load_data    = {XLEN{1'b0}};
        stall        = 1'b0;
        misalign     = 1'b0;
        dm_we        = 1'b0;
        dm_re        = 1'b0;
        dm_addr      = {req_addr[ADDR_W-1:2], 2'b00};
        dm_wdata     = {XLEN{1'b0}};
        capture_s    = 1'b0;
        fault_s      = 1'b0;
        if (rst_n) begin
            case (state_r)
                IDLE: begin
                    if (!req_valid) begin
                        state_next_s = IDLE;
                    end else if (!legal_s || !aligned_s) begin
                        misalign = 1'b1;
                        fault_s  = 1'b1;
                    end else if (!req_we) begin
                        dm_re     = 1'b1;
                        load_data = load_extend(dm_rdata, req_addr[1:0], req_funct3);
                    end else if (req_funct3 == 3'b010) begin
                        dm_we    = 1'b1;
                        dm_wdata = req_wdata;
                    end else begin
                        // Sub-word store: read the old word and hold the pipeline.
                        dm_re        = 1'b1;
                        stall        = 1'b1;
                        capture_s    = 1'b1;
                        state_next_s = WRITE;
                    end
                end
                WRITE: begin
                    // Request inputs are held by the stalled pipeline and ignored here.
                    dm_addr      = cap_addr_r;
                    dm_we        = 1'b1;
                    dm_wdata     = lane_merge(rmw_word_r, cap_off_r, cap_half_r, cap_data_r);
                    state_next_s = IDLE;
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end else begin
            state_next_s = IDLE;
        end
    end

    // State register, RMW capture registers and fault address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            rmw_word_r   <= {XLEN{1'b0}};
            cap_addr_r   <= {ADDR_W{1'b0}};
            cap_off_r    <= 2'd0;
            cap_half_r   <= 1'b0;
            cap_data_r   <= 16'd0;
            fault_addr_r <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (capture_s) begin
                rmw_word_r <= dm_rdata;
                cap_addr_r <= {req_addr[ADDR_W-1:2], 2'b00};
                cap_off_r  <= req_addr[1:0];
                cap_half_r <= req_funct3[0];
                cap_data_r <= req_wdata[15:0];
            end else begin
                rmw_word_r <= rmw_word_r;
            end
            if (fault_s) begin
                fault_addr_r <= req_addr;
            end else begin
                fault_addr_r <= fault_addr_r;
            end
        end
    end

    assign fault_addr = fault_addr_r;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Scoreboard bench: stimulus pushes expected memory-side events computed from
// a byte-level reference memory; a negedge monitor pops and compares whenever
// the DUT shows a strobe (load, RMW read, write, reject).
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int K_LOAD  = 0;
    localparam int K_RMW   = 1;
    localparam int K_WRITE = 2;
    localparam int K_REJ   = 3;

    typedef struct {
        int          kind;
        logic [31:0] value;
        logic [31:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [31:0] load_data;
    logic        stall;
    logic        misalign;
    logic [31:0] fault_addr;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_we;
    logic        dm_re;
    logic [31:0] dm_rdata;

    logic [31:0] dmem [0:255];
    logic [7:0]  ref_mem [0:1023];
    exp_t        exp_q [$];
    logic [31:0] ref_fault = 32'd0;
    int          n_checks = 0;
    int          n_fail = 0;

    load_store_unit #(.ADDR_W(32), .XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .load_data  (load_data),
        .stall      (stall),
        .misalign   (misalign),
        .fault_addr (fault_addr),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_we      (dm_we),
        .dm_re      (dm_re),
        .dm_rdata   (dm_rdata)
    );

    always #5 clk = ~clk;

    // Word memory seen by the DUT: combinational read, posedge write.
    assign dm_rdata = dmem[dm_addr[9:2]];
    always @(posedge clk) begin
        if (dm_we) dmem[dm_addr[9:2]] <= dm_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = int'(a[9:0]) & ~3;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    // Issue one request (called 1 time unit after a rising edge); the expected
    // memory-side events come from the byte-level reference memory, or from
    // the constant k when use_k is set.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit use_k, input logic [31:0] k);
        int     size;
        bit     legal;
        int     cycles;
        longint v;
        exp_t   e;
        int     base;
        cycles = 1;
        size   = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        legal  = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        base   = int'(a[9:0]);
        if (!legal || (base % size) != 0) begin
            e = '{K_REJ, 32'd0, a};
            exp_q.push_back(e);
        end else if (!we) begin
            v = 0;
            for (int i = 0; i < size; i++) v = v + (longint'(ref_mem[base+i]) << (8*i));
            if (f3[2] == 1'b0 && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8*size));
            e = '{K_LOAD, use_k ? k : v[31:0], a & 32'hFFFF_FFFC};
            exp_q.push_back(e);
        end else begin
            for (int i = 0; i < size; i++) ref_mem[base+i] = wd[8*i +: 8];
            if (size < 4) begin
                e = '{K_RMW, 32'd0, a & 32'hFFFF_FFFC};
                exp_q.push_back(e);
                cycles = 2;
            end
            e = '{K_WRITE, use_k ? k : ref_word(a), a & 32'hFFFF_FFFC};
            exp_q.push_back(e);
        end
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Monitor: compares fault_addr every cycle and pops one expected event per
    // cycle in which the DUT drives any strobe.
    always @(negedge clk) begin
        logic [3:0] obs;
        logic [3:0] want;
        exp_t       e;
        if (!rst_n) ref_fault = 32'd0;
        check("fault_addr", fault_addr, ref_fault);
        obs = {dm_we, dm_re, stall, misalign};
        if (obs != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobes", {28'd0, obs}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                case (e.kind)
                    K_LOAD:  want = 4'b0100;
                    K_RMW:   want = 4'b0110;
                    K_WRITE: want = 4'b1000;
                    default: want = 4'b0001;
                endcase
                check("strobes_we_re_stall_mis", {28'd0, obs}, {28'd0, want});
                case (e.kind)
                    K_LOAD: begin
                        check("load_data", load_data, e.value);
                        check("load_dm_addr", dm_addr, e.addr);
                    end
                    K_RMW: begin
                        check("rmw_read_addr", dm_addr, e.addr);
                    end
                    K_WRITE: begin
                        check("dm_wdata", dm_wdata, e.value);
                        check("write_dm_addr", dm_addr, e.addr);
                    end
                    default: begin
                        check("reject_load_data", load_data, 32'd0);
                        ref_fault = e.addr;
                    end
                endcase
            end
        end else begin
            check("idle_load_data", load_data, 32'd0);
        end
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] w;
        // Reset values
        #2;
        check("rst_load_data", load_data, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_dm_we", {31'd0, dm_we}, 32'd0);
        check("rst_dm_re", {31'd0, dm_re}, 32'd0);
        check("rst_fault_addr", fault_addr, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill the whole memory window with random words through SW.
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            issue(1'b1, 3'b010, 32'(i*4), w, 1'b1, w);
        end

        // Directed loads
        issue(1'b1, 3'b010, 32'h100, 32'h112233F4, 1'b1, 32'h112233F4);
        issue(1'b0, 3'b000, 32'h100, 32'd0, 1'b1, 32'hFFFFFFF4);
        issue(1'b0, 3'b100, 32'h100, 32'd0, 1'b1, 32'h000000F4);
        issue(1'b0, 3'b000, 32'h103, 32'd0, 1'b1, 32'h00000011);
        issue(1'b1, 3'b010, 32'h200, 32'h80007FFF, 1'b1, 32'h80007FFF);
        issue(1'b0, 3'b001, 32'h202, 32'd0, 1'b1, 32'hFFFF8000);
        issue(1'b0, 3'b101, 32'h202, 32'd0, 1'b1, 32'h00008000);
        issue(1'b0, 3'b001, 32'h200, 32'd0, 1'b1, 32'h00007FFF);
        // Directed sub-word stores and SW
        issue(1'b1, 3'b010, 32'h100, 32'h11223344, 1'b1, 32'h11223344);
        issue(1'b1, 3'b000, 32'h101, 32'h000000AB, 1'b1, 32'h1122AB44);
        issue(1'b0, 3'b010, 32'h100, 32'd0, 1'b1, 32'h1122AB44);
        issue(1'b1, 3'b010, 32'h100, 32'h11223344, 1'b1, 32'h11223344);
        issue(1'b1, 3'b001, 32'h102, 32'h1234BEEF, 1'b1, 32'hBEEF3344);
        issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
        // Rejected accesses
        issue(1'b0, 3'b010, 32'h102, 32'd0, 1'b0, 32'd0);
        issue(1'b1, 3'b001, 32'h301, 32'h5555, 1'b0, 32'd0);
        issue(1'b0, 3'b011, 32'h104, 32'd0, 1'b0, 32'd0);
        issue(1'b1, 3'b100, 32'h108, 32'd0, 1'b0, 32'd0);

        // Reset asserted in the WRITE cycle of an SB.
        issue(1'b1, 3'b010, 32'h140, 32'h11223344, 1'b1, 32'h11223344);
        exp_q.push_back('{K_RMW, 32'd0, 32'h140});
        req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h141; req_wdata = 32'hAB;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_dm_we", {31'd0, dm_we}, 32'd0);
        check("midrst_dm_re", {31'd0, dm_re}, 32'd0);
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_misalign", {31'd0, misalign}, 32'd0);
        check("midrst_load_data", load_data, 32'd0);
        check("midrst_fault_addr", fault_addr, 32'd0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(1'b0, 3'b010, 32'h140, 32'd0, 1'b1, 32'h11223344);

        // Random traffic against the reference memory.
        for (int n = 0; n < 400; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 1023));
            issue(1'($urandom_range(0, 1)), f3, a, $urandom, 1'b0, 32'd0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
